// File: rtl/pal_word_assembler.sv
// Serial-to-parallel word assembler: gathers an MSB-first bit stream into W-bit words and
// presents them on a registered valid/ready output, with one word of stall capacity,
// start-of-word resynchronisation, a sticky fragment flag and a delivered-word counter.
module pal_word_assembler #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             sof,
  output logic [W-1:0]     word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frag,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  typedef enum logic [0:0] {StFill, StStall} state_e;

  state_e        state_q;
  logic [W-1:0]  sh_q;
  logic [CW-1:0] cnt_q;

  logic          out_free;
  logic          accept;
  logic          consume;
  logic [W-1:0]  shifted;

  // Output slot can take a word this cycle if it is empty or being drained right now.
  assign out_free  = !word_valid || word_ready;
  // Depends on state only, so there is no combinational path from word_ready.
  assign bit_ready = (state_q == StFill);
  assign accept    = bit_valid && bit_ready;
  assign consume   = word_valid && word_ready;
  assign shifted   = {sh_q[W-2:0], bit_in};

  // Assembly FSM, output register, fragment flag and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFill;
      sh_q       <= '0;
      cnt_q      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frag       <= 1'b0;
      word_count <= '0;
    end else begin
      // A load below overrides this clear when both happen in one cycle.
      if (consume) begin
        word_valid <= 1'b0;
        word_count <= word_count + 1'b1;
      end

      unique case (state_q)
        StFill: begin
          if (accept) begin
            sh_q <= shifted;
            if (sof) begin
              // Partial bits already collected are dropped; this bit starts a new word.
              if (cnt_q != '0) frag <= 1'b1;
              cnt_q <= CW'(1);
            end else if (cnt_q == LastCnt) begin
              if (out_free) begin
                word_out   <= shifted;
                word_valid <= 1'b1;
                cnt_q      <= '0;
              end else begin
                // Park the completed word in sh until the output slot frees up.
                state_q <= StStall;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        StStall: begin
          if (out_free) begin
            word_out   <= sh_q;
            word_valid <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StFill;
          end
        end

        default: state_q <= StFill;
      endcase
    end
  end

  // A pending word must not change or vanish while downstream is stalling it.
  assert property (@(posedge clk) disable iff (rst)
    (word_valid && !word_ready) |=> (word_valid && $stable(word_out)));

  // Stalling only happens behind a full output slot.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == StStall) |-> word_valid);

endmodule

// File: doc/pal_word_assembler.md
# pal_word_assembler

Serial-to-parallel front end for the palindrome checker. Collects a serial bit stream MSB-first into W-bit words and presents each completed word on a registered valid/ready output that drives the checker's parallel input. It provides one output holding register, one-word internal stall capacity, start-of-word resynchronisation, a sticky fragment flag and a delivered-word counter.

## Interface
- W, 4: word width in bits; matches the checker input width; W >= 2.
- CNT_W, 8: width of the delivered-word counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  block accepts a bit this cycle; a bit transfers when bit_valid && bit_ready.
- sof  in  1  qualifies the accepted bit as the first bit of a new word.
- word_out  out  W  assembled word; the first received bit is in word_out[W-1].
- word_valid  out  1  word_out holds an undelivered word.
- word_ready  in  1  downstream consumes word_out; a word transfers when word_valid && word_ready.
- frag  out  1  sticky flag: a partial word was discarded by sof.
- word_count  out  CNT_W  number of words delivered, modulo 2^CNT_W.

## Operation
- Storage: shift register sh[W-1:0], bit counter cnt (0..W-1), output register word_out with word_valid, and state FILL or STALL.
- out_free = !word_valid || word_ready.
- FILL: bit_ready = 1.
  - On an accepted bit without sof: sh <= {sh[W-2:0], bit_in}, cnt <= cnt+1.
  - On an accepted bit with sof: if cnt != 0, set frag. Then sh <= {.., bit_in}, cnt <= 1. The prior partial bits are dropped.
  - When the accepted bit completes a word (cnt == W-1, or W == 1 never applies): the completed word is C = {sh[W-2:0], bit_in}.
  - If out_free: word_out <= C, word_valid <= 1, cnt <= 0, stay in FILL.
  - Otherwise: sh <= C, go to STALL.
  - A sof bit completes a word only when W == 1, which is excluded.
- STALL: bit_ready = 0, so sof and bit_in are ignored. When out_free: word_out <= sh, word_valid <= 1, cnt <= 0, go to FILL.
- Output register:
  - If word_valid && word_ready and no new load occurs in the same cycle, word_valid <= 0.
  - A load and a consume in the same cycle leave word_valid = 1 with the new word.
  - While word_valid && !word_ready, word_out is held stable.
- word_count increments by 1 on every word_valid && word_ready and wraps from 2^CNT_W-1 to 0.
- frag is cleared only by rst.
- Reset (rst = 1 at a clock edge):
  - Internal state: state = FILL, cnt = 0, sh = 0.
  - Outputs: word_out = 0, word_valid = 0, frag = 0, word_count = 0.
  - The partial word and the stalled word are discarded.
  - rst overrides every simultaneous event.
- During reset-cycle evaluation, bit_ready = 1 (combinational from state FILL).

## Timing
- Latency: the last bit is accepted at edge N, and word_valid = 1 with the word from the cycle after edge N.
- Throughput: one word per W cycles sustained, with zero bubbles, while word_ready = 1.
- Backpressure:
  - The block absorbs one completed word in sh beyond word_out.
  - bit_ready deasserts in the cycle after the second word completes with word_out still full.
  - bit_ready reasserts in the cycle after the first word_ready handshake.
- bit_ready depends only on state, so there is no combinational path from word_ready.
- word_valid, word_out, frag and word_count are registered outputs.

## Test plan
All scenarios use W = 4 and CNT_W = 8.
- Reset: hold rst 2 cycles with random inputs -> word_out = 0, word_valid = 0, frag = 0, word_count = 0, bit_ready = 1.
- Single word: with word_ready = 1, send bits 1,0,0,1 on 4 consecutive cycles -> word_out = 4'b1001 with word_valid high for exactly 1 cycle after the 4th bit, then word_count = 1.
- Back-to-back: with word_ready = 1, send 1,0,1,1,0,1,1,0 continuously -> 4'b1011 then 4'b0110, each 1 cycle after its 4th bit, no stall, word_count = 2.
- Backpressure:
  - With word_ready = 0, send 1001 then 0110 -> word_out holds 4'b1001, state goes to STALL, bit_ready = 0.
  - Raise word_ready for 1 cycle -> next cycle word_out = 4'b0110 with word_valid = 1 and bit_ready = 1.
- Resync: send 1,1, then a bit 0 with sof = 1, then 1,1,0 -> frag = 1 and word_out = 4'b0110.
- Reset mid-operation: force STALL (as in the backpressure scenario), then assert rst for 1 cycle -> all outputs return to reset values. The next 4 bits 0,1,1,0 produce 4'b0110 and word_count = 1.
